// File: rtl/motor_clk_pkg.sv
// Shared types and constants for the PLL lock / reset / tick block.
package motor_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2
  } lock_state_e;

  localparam int unsigned CLK_HZ_DEFAULT  = 100_000_000;
  localparam int unsigned TICK_HZ_DEFAULT = 1_000_000;
  localparam int unsigned LOCK_LOSS_CNT_W = 8;

endpackage

// File: rtl/pll_lock_reset_tick_bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level; clears to 0.
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw level through the flop chain; oldest sample is the output.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_tick.sv
// PLL lock debouncer, downstream reset generator and clock-enable tick source.
// Optional macro LOCK_LOSS_COUNT_EN adds the saturating lock_loss_cnt output.
module pll_lock_reset_tick
  import motor_clk_pkg::*;
#(
  parameter int unsigned CLK_HZ             = CLK_HZ_DEFAULT,
  parameter int unsigned TICK_HZ            = TICK_HZ_DEFAULT,
  parameter int unsigned SLOW_DIV           = 1000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES        = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked_in,
  output logic sys_rst_out,
  output logic ready,
  output logic tick_fast,
  output logic tick_slow
`ifdef LOCK_LOSS_COUNT_EN
  ,
  output logic [LOCK_LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

  localparam int unsigned DIV_FAST = CLK_HZ / TICK_HZ;
  localparam int unsigned FCNT_W   = $clog2(DIV_FAST);
  localparam int unsigned SCNT_W   = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam int unsigned STAB_W   = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;

  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(DIV_FAST - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SLOW_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);

  // Refuse to build with a divider or window the counters cannot represent.
  if (TICK_HZ == 0 || (CLK_HZ % TICK_HZ) != 0 || (CLK_HZ / TICK_HZ) < 2) begin : g_bad_div
    $error("CLK_HZ must be an integer multiple (>=2) of TICK_HZ");
  end
  if (SLOW_DIV < 1 || LOCK_STABLE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_cfg
    $error("SLOW_DIV>=1, LOCK_STABLE_CYCLES>=1, SYNC_STAGES>=2 required");
  end

  logic              locked_s;
  lock_state_e       state_q, state_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              sys_rst_q, ready_q, tick_fast_q, tick_slow_q;
  logic              run_stay, fire_fast, fire_slow;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked_in),
    .q   (locked_s)
  );

  // Lock qualification: any low sample throws away the stabilization window.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        stab_cnt_d = '0;
        if (locked_s) state_d = STABILIZE;
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d    = WAIT_LOCK;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d    = RUN;
          stab_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      RUN: begin
        stab_cnt_d = '0;
        if (!locked_s) state_d = WAIT_LOCK;
      end
      default: begin
        state_d    = WAIT_LOCK;
        stab_cnt_d = '0;
      end
    endcase
  end

  // Prescalers only run while RUN persists across the edge, so a lock loss
  // landing on a scheduled tick suppresses it and restarts phase from zero.
  always_comb begin
    run_stay  = (state_q == RUN) && (state_d == RUN);
    fire_fast = run_stay && (fcnt_q == FCNT_LAST);
    fire_slow = fire_fast && (scnt_q == SCNT_LAST);
    fcnt_d    = '0;
    scnt_d    = '0;
    if (run_stay) begin
      fcnt_d = fire_fast ? '0 : fcnt_q + 1'b1;
      scnt_d = scnt_q;
      if (fire_fast) scnt_d = fire_slow ? '0 : scnt_q + 1'b1;
    end
  end

  // State, counters and all outputs share one edge; outputs follow next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_LOCK;
      stab_cnt_q  <= '0;
      fcnt_q      <= '0;
      scnt_q      <= '0;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      tick_fast_q <= 1'b0;
      tick_slow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stab_cnt_q  <= stab_cnt_d;
      fcnt_q      <= fcnt_d;
      scnt_q      <= scnt_d;
      sys_rst_q   <= (state_d != RUN);
      ready_q     <= (state_d == RUN);
      tick_fast_q <= fire_fast;
      tick_slow_q <= fire_slow;
    end
  end

  assign sys_rst_out = sys_rst_q;
  assign ready       = ready_q;
  assign tick_fast   = tick_fast_q;
  assign tick_slow   = tick_slow_q;

`ifdef LOCK_LOSS_COUNT_EN
  logic [LOCK_LOSS_CNT_W-1:0] llc_q;

  // Count RUN->WAIT_LOCK drops only; saturates and survives re-lock.
  always_ff @(posedge clk) begin
    if (rst) llc_q <= '0;
    else if ((state_q == RUN) && (state_d == WAIT_LOCK) && (llc_q != '1))
      llc_q <= llc_q + 1'b1;
  end

  assign lock_loss_cnt = llc_q;
`endif

endmodule

// File: tb/tb_pll_lock_reset_tick.sv
// Scoreboard bench: a cycle model pushes expected outputs, a monitor pops and compares.
module tb_pll_lock_reset_tick;

  localparam int S    = 3;
  localparam int L    = 40;
  localparam int DIV  = 10;
  localparam int SLOW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked_in = 1'b0;
  logic sys_rst_out, ready, tick_fast, tick_slow;
  logic [7:0] llc_act;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pll_lock_reset_tick #(
    .CLK_HZ             (100_000_000),
    .TICK_HZ            (10_000_000),
    .SLOW_DIV           (SLOW),
    .LOCK_STABLE_CYCLES (L),
    .SYNC_STAGES        (S)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked_in (pll_locked_in),
    .sys_rst_out   (sys_rst_out),
    .ready         (ready),
    .tick_fast     (tick_fast),
    .tick_slow     (tick_slow)
`ifdef LOCK_LOSS_COUNT_EN
    ,
    .lock_loss_cnt (llc_act)
`endif
  );

`ifndef LOCK_LOSS_COUNT_EN
  assign llc_act = 8'd0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: lock is usable once the synchronized level has been high
  // for L+1 consecutive samples; ticks fall on multiples of the run age.
  logic [S-1:0]    m_sync = '0;
  int              m_streak = 0;
  int              m_age = 0;
  int              m_llc = 0;
  bit              m_run = 0;
  bit              m_prev, m_ls, m_tf, m_ts;
  logic [11:0]     exp_q[$];

  always @(posedge clk) begin
    m_ls   = m_sync[S-1];
    m_prev = m_run;
    if (rst) begin
      m_sync = '0; m_streak = 0; m_run = 0; m_age = 0; m_llc = 0;
    end else begin
      if (!m_ls) m_streak = 0;
      else if (m_streak <= L) m_streak++;
      m_run = (m_streak >= L + 1);
      m_age = (m_prev && m_run) ? m_age + 1 : 0;
`ifdef LOCK_LOSS_COUNT_EN
      if (m_prev && !m_run && m_llc < 255) m_llc++;
`endif
      m_sync = {m_sync[S-2:0], pll_locked_in};
    end
    m_tf = m_prev && m_run && ((m_age % DIV) == 0);
    m_ts = m_tf && ((m_age % (DIV * SLOW)) == 0);
    exp_q.push_back({!m_run, m_run, m_tf, m_ts, 8'(m_llc)});
  end

  // Monitor: the DUT presents a registered output word every cycle.
  logic [11:0] mon_exp;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      chk("cycle_outputs", {20'd0, sys_rst_out, ready, tick_fast, tick_slow, llc_act},
          {20'd0, mon_exp});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Edges from an input change (made at a negedge) until sys_rst_out reaches lvl.
  task automatic meas_rst(input string nm, input logic lvl, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sys_rst_out !== lvl && n < 2000);
    chk(nm, n, exp_n);
  endtask

  task automatic wait_tick(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick_fast !== 1'b1 && n < 2000);
    if (n >= 2000) chk(nm, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nf, ns;
    rst = 1'b1; pll_locked_in = 1'b0;
    cyc(5);
    chk("reset_state", {28'd0, sys_rst_out, ready, tick_fast, tick_slow}, 32'b1000);
    rst = 1'b0;
    cyc(3);

    // Clean lock and first-tick phase.
    pll_locked_in = 1'b1;
    meas_rst("release_latency", 1'b0, S + L + 1);
    chk("ready_at_release", ready, 1);
    wait_tick("first_tick_timeout", n);
    chk("first_tick_delay", n, DIV);

    // Tick rates across a long run.
    nf = 0; ns = 0;
    for (int i = 0; i < 10 * DIV * SLOW; i++) begin
      @(negedge clk);
      if (tick_fast) nf++;
      if (tick_slow) ns++;
    end
    chk("fast_tick_count", nf, 10 * SLOW);
    chk("slow_tick_count", ns, 10);

    // Lock loss in RUN, then a glitch inside the re-stabilization window.
    pll_locked_in = 1'b0;
    meas_rst("lockloss_latency", 1'b1, S + 1);
    chk("ready_after_loss", ready, 0);
    cyc(4);
    pll_locked_in = 1'b1;
    cyc(20);
    pll_locked_in = 1'b0;
    cyc($urandom_range(1, 3));
    pll_locked_in = 1'b1;
    meas_rst("glitch_release", 1'b0, S + L + 1);
    wait_tick("relock_tick_timeout", n);
    chk("relock_tick_phase", n, DIV);

    // Reset landing on the edge of a scheduled tick.
    cyc(DIV - 1);
    rst = 1'b1;
    cyc(1);
    chk("rst_tick_suppress", {29'd0, sys_rst_out, ready, tick_fast}, 32'b100);
    rst = 1'b0;
    meas_rst("rst_restart_release", 1'b0, S + L + 1);

    // Randomized lock behaviour with occasional resets.
    for (int i = 0; i < 120; i++) begin
      pll_locked_in = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 9) == 0);
      cyc(1);
      rst = 1'b0;
      cyc($urandom_range(1, 90));
    end

`ifdef LOCK_LOSS_COUNT_EN
    rst = 1'b1; pll_locked_in = 1'b0;
    cyc(2);
    rst = 1'b0;
    chk("llc_after_rst", llc_act, 0);
    pll_locked_in = 1'b1;
    meas_rst("llc_release_a", 1'b0, S + L + 1);
    pll_locked_in = 1'b0;
    cyc(S + 3);
    chk("llc_one_loss", llc_act, 1);
    pll_locked_in = 1'b1;
    cyc(S + 5);
    pll_locked_in = 1'b0;
    cyc(1);
    pll_locked_in = 1'b1;
    cyc(S + 3);
    chk("llc_stab_glitch", llc_act, 1);
    for (int i = 0; i < 300; i++) begin
      pll_locked_in = 1'b1;
      meas_rst("llc_loop_release", 1'b0, S + L + 1);
      cyc(2);
      pll_locked_in = 1'b0;
      cyc(S + 3);
    end
    chk("llc_saturate", llc_act, 255);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("llc_rst_clear", llc_act, 0);
`endif

    cyc(3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
